// File: rtl/ldpc_fifo_arb_pkg.sv
// ldpc_fifo_arb_pkg: shared state type and sizing helper for the LDPC FIFO write-port arbiter
package ldpc_fifo_arb_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} arb_state_t;
  function automatic int grant_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ldpc_rr_picker.sv
// ldpc_rr_picker: combinational round-robin picker, first request strictly after ptr, modulo N
module ldpc_rr_picker
  import ldpc_fifo_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = grant_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] index
);
  logic [W-1:0] cand;
  // Walk the ring backwards so the candidate closest to ptr+1 is assigned last and wins
  always_comb begin
    found = 1'b0;
    index = '0;
    cand = '0;
    for (int i = N; i >= 1; i--) begin
      cand = W'((int'(ptr) + i) % N);
      if (req[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end
endmodule

// File: rtl/ldpc_fifo_arbiter.sv
// ldpc_fifo_arbiter: frame-locked round-robin sharing of the LDPC input FIFO write port
// with a max-length watchdog, sticky per-requester overlength flags and a frame counter.
module ldpc_fifo_arbiter
  import ldpc_fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 2048,
  parameter int CNT_W     = 16,
  parameter int GW        = grant_width(N_REQ),
  parameter int BW        = $clog2(MAX_BEATS + 1)
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic [N_REQ*WIDTH-1:0] i_in_data,
  input  logic [N_REQ-1:0]       i_in_valid,
  input  logic [N_REQ-1:0]       i_in_last,
  output logic [N_REQ-1:0]       o_in_ready,
  output logic [WIDTH-1:0]       o_out_data,
  output logic                   o_out_valid,
  output logic                   o_out_last,
  input  logic                   i_out_ready,
  output logic [GW-1:0]          o_grant,
  output logic                   o_busy,
  output logic [N_REQ-1:0]       o_err_overlength,
  input  logic                   i_err_clear,
  output logic [CNT_W-1:0]       o_frame_count
);
  arb_state_t state;
  logic [GW-1:0] grant, rr_ptr, pick_idx;
  logic [BW-1:0] beat_cnt;
  logic pick_found, accept, at_max, frame_end;
  logic [N_REQ-1:0] err_set;
  ldpc_rr_picker #(.N(N_REQ), .W(GW)) u_picker (
    .req  (i_in_valid),
    .ptr  (rr_ptr),
    .found(pick_found),
    .index(pick_idx)
  );
  always_comb begin
    o_out_data = '0;
    for (int k = 0; k < N_REQ; k++)
      if (grant == GW'(k)) o_out_data = i_in_data[k*WIDTH +: WIDTH];
  end
  assign o_grant     = grant;
  assign o_busy      = state == ST_BUSY;
  assign o_out_valid = o_busy & i_in_valid[grant];
  assign o_in_ready  = (o_busy & i_out_ready) ? N_REQ'(1) << grant : '0;
  assign at_max      = beat_cnt == BW'(MAX_BEATS - 1);
  assign o_out_last  = o_busy & (i_in_last[grant] | at_max);
  assign accept      = o_out_valid & i_out_ready;
  assign frame_end   = accept & o_out_last;
  // A frame ending without the requester's own last flag was cut by the watchdog
  assign err_set     = (frame_end & ~i_in_last[grant]) ? N_REQ'(1) << grant : '0;
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state            <= ST_IDLE;
      grant            <= '0;
      rr_ptr           <= GW'(N_REQ - 1);
      beat_cnt         <= '0;
      o_err_overlength <= '0;
      o_frame_count    <= '0;
    end else begin
      o_err_overlength <= (i_err_clear ? '0 : o_err_overlength) | err_set;
      if (state == ST_IDLE) begin
        if (pick_found) begin
          grant <= pick_idx;
          state <= ST_BUSY;
        end
      end else if (accept) begin
        beat_cnt <= frame_end ? '0 : beat_cnt + 1'b1;
        if (frame_end) begin
          state         <= ST_IDLE;
          rr_ptr        <= grant;
          o_frame_count <= o_frame_count + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ldpc_fifo_arbiter.sv
// tb_ldpc_fifo_arbiter: randomized and directed checks of ldpc_fifo_arbiter against a
// frame-level reference model driven from per-requester beat queues.
module tb_ldpc_fifo_arbiter;
  localparam int N = 4;
  localparam int MAXB = 8;
  logic i_clock = 1'b0;
  logic i_reset_n = 1'b1;
  logic [N*8-1:0] i_in_data = '0;
  logic [N-1:0] i_in_valid = '0, i_in_last = '0, o_in_ready, o_err_overlength;
  logic [7:0] o_out_data;
  logic o_out_valid, o_out_last, o_busy;
  logic i_out_ready = 1'b0, i_err_clear = 1'b0;
  logic [1:0] o_grant;
  logic [3:0] o_frame_count;
  always #5 i_clock = ~i_clock;
  ldpc_fifo_arbiter #(.N_REQ(N), .WIDTH(8), .MAX_BEATS(MAXB), .CNT_W(4)) dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_in_data(i_in_data), .i_in_valid(i_in_valid),
    .i_in_last(i_in_last), .o_in_ready(o_in_ready), .o_out_data(o_out_data),
    .o_out_valid(o_out_valid), .o_out_last(o_out_last), .i_out_ready(i_out_ready),
    .o_grant(o_grant), .o_busy(o_busy), .o_err_overlength(o_err_overlength),
    .i_err_clear(i_err_clear), .o_frame_count(o_frame_count)
  );
  int checks = 0, errors = 0;
  logic [8:0] q [N][$];
  logic [N-1:0] held;
  bit gaps, rnd, clr_req;
  int stall, beats_out, cyc, pushed;
  bit m_busy;
  logic [1:0] m_owner, m_ptr;
  int m_beats;
  logic [3:0] m_count, m_err;
  int grants[$];
  function automatic bit pending();
    pending = m_busy;
    for (int k = 0; k < N; k++) if (q[k].size() != 0) pending = 1'b1;
  endfunction
  task automatic push_frame(input int k, input int len, input bit rand_data, input logic [7:0] base, input bit with_last);
    for (int i = 0; i < len; i++) begin
      q[k].push_back({with_last && (i == len - 1), rand_data ? 8'($urandom) : 8'(base + 8'(i))});
      pushed++;
    end
  endtask
  // One clock: drive requesters from their queues, compare DUT against the model, advance the model
  task automatic step();
    logic [N-1:0] acc, set, exp_ready;
    logic [8:0] b;
    logic [1:0] j;
    bit fl, fnd, exp_valid, exp_last;
    for (int k = 0; k < N; k++) begin
      b = q[k].size() != 0 ? q[k][0] : 9'h000;
      if (q[k].size() == 0) i_in_valid[k] = 1'b0;
      else if (!held[k]) i_in_valid[k] = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_in_data[k*8 +: 8] = b[7:0];
      i_in_last[k] = b[8];
    end
    if (stall > 0) begin
      i_out_ready = 1'b0;
      stall--;
    end else i_out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    i_err_clear = rnd ? ($urandom_range(0, 15) == 0) : clr_req;
    #1;
    checks += 4;
    if (o_busy !== m_busy) begin errors++; $display("FAIL busy cyc=%0d got %b exp %b", cyc, o_busy, m_busy); end
    if (o_grant !== m_owner) begin errors++; $display("FAIL grant cyc=%0d got %0d exp %0d", cyc, o_grant, m_owner); end
    if (o_frame_count !== m_count) begin errors++; $display("FAIL frame_count cyc=%0d got %0d exp %0d", cyc, o_frame_count, m_count); end
    if (o_err_overlength !== m_err) begin errors++; $display("FAIL err cyc=%0d got %b exp %b", cyc, o_err_overlength, m_err); end
    exp_valid = m_busy && i_in_valid[m_owner];
    exp_ready = (m_busy && i_out_ready) ? 4'b0001 << m_owner : 4'b0000;
    checks += 2;
    if (o_out_valid !== exp_valid) begin errors++; $display("FAIL out_valid cyc=%0d got %b exp %b", cyc, o_out_valid, exp_valid); end
    if (o_in_ready !== exp_ready) begin errors++; $display("FAIL in_ready cyc=%0d got %b exp %b", cyc, o_in_ready, exp_ready); end
    if (exp_valid) begin
      b = q[m_owner][0];
      exp_last = b[8] || (m_beats == MAXB - 1);
      checks += 2;
      if (o_out_data !== b[7:0]) begin errors++; $display("FAIL out_data cyc=%0d got %h exp %h", cyc, o_out_data, b[7:0]); end
      if (o_out_last !== exp_last) begin errors++; $display("FAIL out_last cyc=%0d got %b exp %b", cyc, o_out_last, exp_last); end
    end
    acc = '0;
    set = '0;
    if (!m_busy) begin
      fnd = 1'b0;
      for (int i = 1; i <= N; i++) begin
        j = 2'(int'(m_ptr) + i);
        if (!fnd && i_in_valid[j]) begin
          fnd = 1'b1;
          m_owner = j;
        end
      end
      if (fnd) begin
        m_busy = 1'b1;
        grants.push_back(int'(m_owner));
      end
    end else if (i_in_valid[m_owner] && i_out_ready) begin
      acc[m_owner] = 1'b1;
      b = q[m_owner].pop_front();
      beats_out++;
      fl = b[8] || (m_beats == MAXB - 1);
      if (fl) begin
        if (!b[8]) set[m_owner] = 1'b1;
        m_busy = 1'b0;
        m_ptr = m_owner;
        m_beats = 0;
        m_count++;
      end else m_beats++;
    end
    m_err = (i_err_clear ? 4'b0000 : m_err) | set;
    held = i_in_valid & ~acc;
    cyc++;
    @(posedge i_clock);
    #1;
  endtask
  task automatic drain(input int limit);
    int n = 0;
    while (pending() && n < limit) begin
      step();
      n++;
    end
    checks++;
    if (pending()) begin errors++; $display("FAIL drain_timeout got %0d cycles exp <%0d", n, limit); end
  endtask
  task automatic run_until_beats(input int target, input int limit);
    int n = 0;
    while (beats_out < target && n < limit) begin
      step();
      n++;
    end
    checks++;
    if (beats_out < target) begin errors++; $display("FAIL beat_timeout got %0d exp %0d", beats_out, target); end
  endtask
  task automatic reset_dut();
    i_reset_n = 1'b0;
    i_in_valid = '0;
    i_out_ready = 1'b0;
    i_err_clear = 1'b0;
    for (int k = 0; k < N; k++) q[k].delete();
    grants.delete();
    held = '0;
    gaps = 0; rnd = 0; clr_req = 0; stall = 0;
    beats_out = 0; pushed = 0;
    m_busy = 0; m_owner = 2'd0; m_ptr = 2'd3; m_beats = 0; m_count = '0; m_err = '0;
    repeat (2) @(posedge i_clock);
    #1 i_reset_n = 1'b1;
  endtask
  task automatic test_reset();
    reset_dut();
    checks += 5;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", o_busy); end
    if (o_in_ready !== 4'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0000", o_in_ready); end
    if (o_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", o_out_valid); end
    if (o_grant !== 2'd0) begin errors++; $display("FAIL rst_grant got %0d exp 0", o_grant); end
    if (o_frame_count !== 4'd0 || o_err_overlength !== 4'd0) begin errors++; $display("FAIL rst_counters got %0d/%b exp 0/0000", o_frame_count, o_err_overlength); end
  endtask
  task automatic test_reset_mid_frame();
    reset_dut();
    push_frame(1, 6, 0, 8'h40, 1);
    run_until_beats(2, 20);
    i_reset_n = 1'b0;
    #1;
    checks += 4;
    if (o_in_ready !== 4'b0) begin errors++; $display("FAIL async_in_ready got %b exp 0000", o_in_ready); end
    if (o_out_valid !== 1'b0) begin errors++; $display("FAIL async_out_valid got %b exp 0", o_out_valid); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL async_busy got %b exp 0", o_busy); end
    if (o_grant !== 2'd0) begin errors++; $display("FAIL async_grant got %0d exp 0", o_grant); end
    reset_dut();
    push_frame(2, 1, 0, 8'h50, 1);
    push_frame(0, 1, 0, 8'h51, 1);
    step();
    checks++;
    if (o_grant !== 2'd0) begin errors++; $display("FAIL post_reset_grant got %0d exp 0", o_grant); end
    drain(50);
  endtask
  task automatic test_single();
    int b0;
    reset_dut();
    push_frame(2, 5, 0, 8'h10, 1);
    step();
    checks += 2;
    if (o_grant !== 2'd2) begin errors++; $display("FAIL single_grant got %0d exp 2", o_grant); end
    if (o_busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", o_busy); end
    b0 = beats_out;
    repeat (5) step();
    checks += 3;
    if (beats_out - b0 != 5) begin errors++; $display("FAIL single_consecutive got %0d exp 5", beats_out - b0); end
    if (o_frame_count !== 4'd1) begin errors++; $display("FAIL single_count got %0d exp 1", o_frame_count); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL single_idle got %b exp 0", o_busy); end
  endtask
  task automatic test_round_robin();
    int c0;
    int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    reset_dut();
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < N; k++) push_frame(k, 3, 0, 8'(k * 16 + f * 4), 1);
    c0 = cyc;
    drain(200);
    checks += 3;
    if (grants.size() != 8) begin errors++; $display("FAIL rr_grants got %0d exp 8", grants.size()); end
    else for (int i = 0; i < 8; i++)
      if (grants[i] != exp_order[i]) begin errors++; $display("FAIL rr_order idx=%0d got %0d exp %0d", i, grants[i], exp_order[i]); end
    if (cyc - c0 != 32) begin errors++; $display("FAIL rr_cycles got %0d exp 32", cyc - c0); end
    if (o_frame_count !== 4'd8) begin errors++; $display("FAIL rr_count got %0d exp 8", o_frame_count); end
  endtask
  task automatic test_backpressure();
    reset_dut();
    push_frame(1, 6, 0, 8'h20, 1);
    run_until_beats(2, 20);
    stall = 4;
    for (int i = 0; i < 4; i++) begin
      step();
      checks += 2;
      if (o_out_data !== 8'h22) begin errors++; $display("FAIL bp_hold_data i=%0d got %h exp 22", i, o_out_data); end
      if (o_in_ready !== 4'b0) begin errors++; $display("FAIL bp_in_ready i=%0d got %b exp 0000", i, o_in_ready); end
    end
    drain(50);
    checks += 2;
    if (beats_out != 6) begin errors++; $display("FAIL bp_beats got %0d exp 6", beats_out); end
    if (o_frame_count !== 4'd1) begin errors++; $display("FAIL bp_count got %0d exp 1", o_frame_count); end
  endtask
  task automatic test_overlength();
    reset_dut();
    push_frame(3, 10, 0, 8'h30, 1);
    run_until_beats(8, 30);
    checks += 2;
    if (o_err_overlength !== 4'b1000) begin errors++; $display("FAIL ovl_flag got %b exp 1000", o_err_overlength); end
    if (o_frame_count !== 4'd1) begin errors++; $display("FAIL ovl_split got %0d exp 1", o_frame_count); end
    drain(30);
    checks++;
    if (o_frame_count !== 4'd2) begin errors++; $display("FAIL ovl_second got %0d exp 2", o_frame_count); end
    clr_req = 1;
    step();
    clr_req = 0;
    checks++;
    if (o_err_overlength !== 4'b0) begin errors++; $display("FAIL ovl_clear got %b exp 0000", o_err_overlength); end
  endtask
  task automatic test_counter_wrap();
    reset_dut();
    for (int i = 0; i < 17; i++) push_frame($urandom_range(0, 3), 1, 1, 8'h00, 1);
    drain(400);
    checks++;
    if (o_frame_count !== 4'd1) begin errors++; $display("FAIL wrap_count got %0d exp 1", o_frame_count); end
  endtask
  task automatic test_random();
    reset_dut();
    gaps = 1;
    rnd = 1;
    for (int i = 0; i < 40; i++) push_frame($urandom_range(0, 3), $urandom_range(1, 11), 1, 8'h00, 1);
    drain(8000);
    checks++;
    if (beats_out != pushed) begin errors++; $display("FAIL rand_beats got %0d exp %0d", beats_out, pushed); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overlength();
    test_reset_mid_frame();
    test_counter_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ldpc_fifo_arbiter.md
Name: ldpc_fifo_arbiter

Overview:
- Shares the single write port of the LDPC decoder input FIFO between N codeword producers, e.g. multiple demapper lanes.
- Arbitration is round-robin and frame-locked: once a requester is granted, it keeps the port until its last beat is accepted.
- Guards against runaway frames with a maximum-length watchdog, and reports per-requester errors plus a frame count.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- WIDTH, 8, data width per beat; matches the FIFO WIDTH.
- MAX_BEATS, 2048, maximum beats per frame before forced termination.
- CNT_W, 16, width of the frame counter.

Ports:
- i_clock  in  1  clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_in_data  in  N_REQ*WIDTH  requester data; requester k occupies bits [k*WIDTH +: WIDTH].
- i_in_valid  in  N_REQ  per-requester valid.
- i_in_last  in  N_REQ  per-requester end-of-frame flag, qualified by valid.
- o_in_ready  out  N_REQ  per-requester ready.
- o_out_data  out  WIDTH  to the FIFO write data.
- o_out_valid  out  1  to the FIFO write valid.
- o_out_last  out  1  frame end of the current beat (sideband to the frame tracker).
- i_out_ready  in  1  from the FIFO in-ready.
- o_grant  out  max(1,$clog2(N_REQ))  index of the current or last owner.
- o_busy  out  1  a frame is in progress.
- o_err_overlength  out  N_REQ  sticky per-requester overlength flags.
- i_err_clear  in  1  synchronous clear of o_err_overlength.
- o_frame_count  out  CNT_W  completed frames; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync release): state=ST_IDLE, grant=0, rr_ptr=N_REQ-1, beat_cnt=0, o_err_overlength=0, o_frame_count=0.
  - All outputs combinationally derived from this state, so o_in_ready=0, o_out_valid=0, o_busy=0.
- States: ST_IDLE, ST_BUSY.
- ST_IDLE:
  - o_in_ready=0 and o_out_valid=0.
  - If any i_in_valid is set, pick the first valid requester searching from rr_ptr+1 upward, modulo N_REQ.
  - Register that index as grant and go to ST_BUSY. No valid requester: stay in ST_IDLE.
- ST_BUSY:
  - Zero-latency combinational pass-through for the granted requester g:
    - o_out_data = i_in_data[g]
    - o_out_valid = i_in_valid[g]
    - o_in_ready[g] = i_out_ready; all other o_in_ready bits are 0.
  - o_busy=1.
- Beat accepted (o_out_valid & i_out_ready):
  - beat_cnt increments.
  - o_out_last = i_in_last[g] | (beat_cnt == MAX_BEATS-1).
- Frame end (accepted beat with o_out_last=1):
  - state goes to ST_IDLE, rr_ptr=g, beat_cnt=0, o_frame_count increments.
  - Exactly one bubble cycle between frames; the next grant is decided in that IDLE cycle.
- Forced termination (beat_cnt==MAX_BEATS-1 accepted with i_in_last[g]=0):
  - o_out_last is forced to 1 and o_err_overlength[g] is set.
  - The requester's remaining beats form a new frame under normal arbitration.
- Backpressure: if i_out_ready=0 (FIFO full), state, grant and beat_cnt hold. The requester must hold its data and valid stable.
- Idle owner: if valid[g]=0 mid-frame, the grant is held and other requesters wait.
- i_err_clear and a same-cycle new overlength error: the set wins for that bit; all other bits clear.
- Width rules:
  - beat_cnt is $clog2(MAX_BEATS+1) bits and never exceeds MAX_BEATS-1.
  - o_frame_count wraps from 2^CNT_W-1 to 0.
- Reset mid-frame aborts the frame immediately. The FIFO must be reset in the same domain by the integrator.

Decomposition:
- Package ldpc_fifo_arb_pkg holds:
  - the state enum type (ST_IDLE, ST_BUSY);
  - function grant_width(n) returning max(1,$clog2(n)).
- Sub-module ldpc_rr_picker: combinational round-robin picker.
  - Inputs: request vector, rr_ptr.
  - Outputs: found, index.
  - Reusable for the later check-node scheduler.

Test Plan:
- Single requester:
  - Stimulus: N_REQ=4; requester 2 sends a 5-beat frame 0x10..0x14, last on 0x14, i_out_ready=1.
  - Required: grant=2 on cycle 1 after valid; 5 outputs on consecutive cycles; o_out_last on 0x14; o_frame_count=1.
- Round-robin fairness:
  - Stimulus: all 4 requesters continuously valid with 3-beat frames.
  - Required: grant order 0,1,2,3,0,...; each frame contiguous; one idle cycle between frames.
- Backpressure:
  - Stimulus: i_out_ready=0 for 4 cycles mid-frame of requester 1.
  - Required: o_out_data holds, o_in_ready[1]=0, beat_cnt unchanged; frame resumes with no lost or duplicated beats.
- Overlength:
  - Stimulus: MAX_BEATS=8; requester 3 sends 10 beats with no last.
  - Required: beat 8 carries o_out_last=1 and o_err_overlength=4'b1000; beats 9–10 form a new frame; i_err_clear then returns flags to 0.
- Reset mid-frame:
  - Stimulus: assert i_reset_n=0 after beat 2 of 6.
  - Required: o_in_ready, o_out_valid and o_busy go 0 asynchronously; after release grant=0, o_frame_count=0, and the next grant searches from 0.
- Counter wrap:
  - Stimulus: CNT_W=4; 17 one-beat frames.
  - Required: o_frame_count reads 1 after the 17th frame.
